wbu_cw_serial: RTL and testbench

WBU_CW_SERIAL -- requirements
Module: wbu_cw_serial

---
 rtl/wbu_cw_serial_pkg.sv | 18 +
 rtl/wbu_cw_serial.sv | 89 ++++++++
 tb/tb_wbu_cw_serial.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/wbu_cw_serial_pkg.sv
// -----------------------------------------------------------------------------
// wbu_cw_serial_pkg
// Shared definitions for the wbu codeword serialiser: the default codeword and
// chunk widths, and the two-state FSM encoding.
// -----------------------------------------------------------------------------
package wbu_cw_serial_pkg;

    // Default codeword width, as popped from the upstream FIFO.
    localparam int WBU_BW = 36;
    // Default output chunk width; WBU_BW is an integer multiple of it.
    localparam int WBU_CW = 6;

    typedef enum logic {
        S_IDLE = 1'b0,  // no codeword held
        S_SEND = 1'b1   // emitting chunks of the held codeword
    } cw_state_e;

endpackage : wbu_cw_serial_pkg

// File: rtl/wbu_cw_serial.sv
// -----------------------------------------------------------------------------
// wbu_cw_serial
// Pops BW-bit codewords from a pre-presenting FIFO and emits each one as BW/CW
// chunks of CW bits, MSB first, one chunk per cycle when the sink is ready.
// Back-to-back codewords stream with no bubble: the next word is popped in the
// same cycle the last chunk of the current one transfers.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_fifo_empty_n FIFO head word valid
//   i_fifo_data    FIFO head word (BW bits)
//   o_fifo_rd      pop strobe, combinational, one cycle per codeword
//   o_stb          chunk valid
//   o_chunk        current chunk (CW bits)
//   o_last         final chunk of the codeword
//   i_busy         downstream stall; transfer happens on o_stb && !i_busy
//   o_idle         no codeword held
// -----------------------------------------------------------------------------
module wbu_cw_serial
    import wbu_cw_serial_pkg::*;
#(
    parameter int BW = WBU_BW,
    parameter int CW = WBU_CW
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_fifo_empty_n,
    input  logic [BW-1:0] i_fifo_data,
    output logic          o_fifo_rd,
    output logic          o_stb,
    output logic [CW-1:0] o_chunk,
    output logic          o_last,
    input  logic          i_busy,
    output logic          o_idle
);

    localparam int NCHUNK = BW / CW;
    localparam int CNTW   = $clog2(NCHUNK);
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NCHUNK - 1);

    generate
        if ((BW % CW) != 0 || NCHUNK < 2) begin : g_bad_widths
            $error("wbu_cw_serial: BW must be a multiple of CW with BW/CW >= 2");
        end
    endgenerate

    cw_state_e       state_q;
    logic [BW-1:0]   sreg_q;
    logic [CNTW-1:0] cnt_q;
    logic            xfer;

    // Chunk outputs come straight from registers, so they stay stable under a
    // stall without any extra hold logic.
    assign o_stb   = (state_q == S_SEND);
    assign o_chunk = sreg_q[BW-1 -: CW];
    assign o_last  = o_stb && (cnt_q == LAST_CNT);
    assign o_idle  = (state_q == S_IDLE);
    assign xfer    = o_stb && !i_busy;

    // Pop when empty-handed, or when the last chunk leaves this cycle so the
    // next word is loaded with no gap. Gated by reset so no pop can be seen
    // before the first edge after release.
    assign o_fifo_rd = i_rst_n && i_fifo_empty_n && (o_idle || (xfer && o_last));

    // NOTE: every register here uses non-blocking assignment so all state
    // updates see the pre-edge values; blocking would create order-dependent
    // races between the shift register, counter and state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
        end else if (o_fifo_rd) begin
            state_q <= S_SEND;
            sreg_q  <= i_fifo_data;
            cnt_q   <= '0;
        end else if (xfer) begin
            if (o_last) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
            end else begin
                sreg_q <= sreg_q << CW;
                cnt_q  <= cnt_q + CNTW'(1);
            end
        end
    end

endmodule : wbu_cw_serial

// File: tb/tb_wbu_cw_serial.sv
// -----------------------------------------------------------------------------
// tb_wbu_cw_serial
// Self-checking bench for wbu_cw_serial. A queue-based model holds the FIFO
// contents and the chunks still owed for the current codeword; every cycle the
// DUT outputs are compared against what that model says must be visible.
// -----------------------------------------------------------------------------
module tb_wbu_cw_serial;

    localparam int BW = 36;
    localparam int CW = 6;
    localparam int NCHUNK = BW / CW;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_fifo_empty_n;
    logic [BW-1:0] i_fifo_data;
    logic          o_fifo_rd;
    logic          o_stb;
    logic [CW-1:0] o_chunk;
    logic          o_last;
    logic          i_busy;
    logic          o_idle;

    wbu_cw_serial #(.BW(BW), .CW(CW)) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_fifo_empty_n (i_fifo_empty_n),
        .i_fifo_data    (i_fifo_data),
        .o_fifo_rd      (o_fifo_rd),
        .o_stb          (o_stb),
        .o_chunk        (o_chunk),
        .o_last         (o_last),
        .i_busy         (i_busy),
        .o_idle         (o_idle)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model state
    logic [BW-1:0] fifo_q[$];   // words waiting in the upstream FIFO
    logic [CW-1:0] owed_q[$];   // chunks of the held codeword not yet sent
    logic [CW-1:0] sent_q[$];   // chunks that transferred (per test log)
    int            pop_count;
    int            stb_count;
    int            rd_hist[$];  // step indices where a pop was seen

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Chunk k of word w, MSB first, by plain arithmetic.
    function automatic logic [CW-1:0] chunk_of(input logic [BW-1:0] w, input int k);
        logic [BW-1:0] t;
        t = w >> (BW - CW * (k + 1));
        return t[CW-1:0];
    endfunction

    function automatic logic [BW-1:0] rand_word();
        return {4'($urandom), 32'($urandom)};
    endfunction

    // One cycle: drive inputs (we are #1 after a rising edge), compare at the
    // falling edge, then advance the model for the coming rising edge.
    task automatic step(input logic busy, input logic offer, input int idx);
        logic exp_stb, exp_last, exp_rd, have;
        logic [CW-1:0] exp_chunk;
        logic [BW-1:0] w;
        have           = offer && (fifo_q.size() > 0);
        i_busy         = busy;
        i_fifo_empty_n = have;
        i_fifo_data    = have ? fifo_q[0] : rand_word();
        @(negedge i_clk);
        exp_stb   = (owed_q.size() > 0);
        exp_last  = (owed_q.size() == 1);
        exp_chunk = exp_stb ? owed_q[0] : '0;
        exp_rd    = have && (!exp_stb || (!busy && exp_last));
        check("o_stb", 64'(o_stb), 64'(exp_stb));
        check("o_last", 64'(o_last), 64'(exp_last));
        check("o_idle", 64'(o_idle), 64'(!exp_stb));
        check("o_fifo_rd", 64'(o_fifo_rd), 64'(exp_rd));
        if (exp_stb) check("o_chunk", 64'(o_chunk), 64'(exp_chunk));
        if (o_fifo_rd) rd_hist.push_back(idx);
        if (o_stb) stb_count++;
        if (exp_stb && !busy) sent_q.push_back(owed_q.pop_front());
        if (exp_rd) begin
            w = fifo_q.pop_front();
            pop_count++;
            for (int k = 0; k < NCHUNK; k++) owed_q.push_back(chunk_of(w, k));
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_log();
        sent_q.delete();
        rd_hist.delete();
        pop_count = 0;
        stb_count = 0;
    endtask

    task automatic check_seq(input string name, input logic [CW-1:0] exp[6], input int base);
        for (int k = 0; k < 6; k++) begin
            if (base + k < sent_q.size()) check(name, 64'(sent_q[base + k]), 64'(exp[k]));
            else check(name, 64'hDEAD, 64'(exp[k]));
        end
    endtask

    initial begin
        logic [CW-1:0] seq_a[6];
        logic [CW-1:0] seq_f[6];
        int            cyc;
        seq_a = '{6'h04, 6'h23, 6'h11, 6'h16, 6'h1E, 6'h09};
        seq_f = '{6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F, 6'h3F};

        // Reset state, with a valid FIFO head present to show the pop is gated.
        i_rst_n        = 1'b0;
        i_busy         = 1'b0;
        i_fifo_empty_n = 1'b1;
        i_fifo_data    = 36'h123456789;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_stb", 64'(o_stb), 64'd0);
        check("rst_last", 64'(o_last), 64'd0);
        check("rst_chunk", 64'(o_chunk), 64'd0);
        check("rst_idle", 64'(o_idle), 64'd1);
        check("rst_rd", 64'(o_fifo_rd), 64'd0);
        i_fifo_empty_n = 1'b0;
        i_rst_n = 1'b1;
        clear_log();

        // Single word, no stall.
        fifo_q.push_back(36'h123456789);
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1, i);
        check_seq("single_seq", seq_a, 0);
        check("single_pops", 64'(pop_count), 64'd1);
        check("single_idle", 64'(o_idle), 64'd1);

        // Two words back-to-back: 12 strobes, pops at steps 0 and 6 only.
        clear_log();
        fifo_q.push_back(36'h123456789);
        fifo_q.push_back(36'hFFFFFFFFF);
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, i);
        check("b2b_stb_count", 64'(stb_count), 64'd12);
        check("b2b_pop_count", 64'(rd_hist.size()), 64'd2);
        if (rd_hist.size() == 2) begin
            check("b2b_pop0", 64'(rd_hist[0]), 64'd0);
            check("b2b_pop1", 64'(rd_hist[1]), 64'd6);
        end
        check_seq("b2b_seq0", seq_a, 0);
        check_seq("b2b_seq1", seq_f, 6);

        // Stall three cycles while chunk 0x11 is presented.
        clear_log();
        fifo_q.push_back(36'h123456789);
        step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 1);
        step(1'b0, 1'b1, 2);
        for (int i = 0; i < 3; i++) begin
            check("stall_chunk", 64'(o_chunk), 64'h11);
            check("stall_stb", 64'(o_stb), 64'd1);
            step(1'b1, 1'b1, 3 + i);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 6 + i);
        check_seq("stall_seq", seq_a, 0);
        check("stall_pops", 64'(pop_count), 64'd1);

        // Empty FIFO for 100 cycles.
        clear_log();
        for (int i = 0; i < 100; i++) step(i[0], 1'b1, i);
        check("empty_pops", 64'(pop_count), 64'd0);
        check("empty_stb", 64'(stb_count), 64'd0);

        // Reset after three chunks; the partial word is dropped.
        clear_log();
        fifo_q.push_back(36'h123456789);
        fifo_q.push_back(36'hFFFFFFFFF);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, i);
        i_rst_n = 1'b0;
        #1;
        check("midrst_stb", 64'(o_stb), 64'd0);
        check("midrst_chunk", 64'(o_chunk), 64'd0);
        check("midrst_idle", 64'(o_idle), 64'd1);
        check("midrst_rd", 64'(o_fifo_rd), 64'd0);
        owed_q.delete();
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        clear_log();
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, i);
        check("midrst_pops", 64'(pop_count), 64'd1);
        check_seq("midrst_seq", seq_f, 0);
        check("midrst_sent", 64'(sent_q.size()), 64'd6);

        // Randomised traffic against the model.
        clear_log();
        for (int i = 0; i < 10000; i++) begin
            if (fifo_q.size() < 3 && $urandom_range(0, 3) != 0) fifo_q.push_back(rand_word());
            step($urandom_range(0, 2) == 0, $urandom_range(0, 9) < 7, i);
        end
        cyc = 0;
        while ((owed_q.size() > 0 || fifo_q.size() > 0) && cyc < 200) begin
            step(1'b0, 1'b1, cyc);
            cyc++;
        end
        check("drain_done", 64'(cyc < 200), 64'd1);
        check("rand_idle", 64'(o_idle), 64'd1);
        check("rand_chunks", 64'(sent_q.size()), 64'(pop_count * NCHUNK));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_wbu_cw_serial
